fft_stream_core: RTL and testbench

Parametrised, streaming successor to the fixed 16-point FFT processor. It accepts a stream of real audio samples and buffers one frame of N = 2^LOG2N samples. It computes an in-place iterative radix-2 decimation-in-time FFT with one butterfly per cycle, then streams the N complex bins out in natural order. It sits between the audio sample source and the visualiser's bin/bar logic, with valid/ready handshakes on both sides.

---
 rtl/fft_stream_if.sv | 26 ++
 rtl/fft_stream_core.sv | 214 +++++++++++++++++++++
 tb/tb_fft_stream_core.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stream_if.sv
// Stream bundle for fft_stream_core: real samples in, complex bins out,
// each side with its own valid/ready handshake.
interface fft_stream_if #(
    parameter int LOG2N = 4,
    parameter int DW    = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DW-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [DW-1:0]    out_re;
    logic signed [DW-1:0]    out_im;
    logic [LOG2N-1:0]        out_index;
    logic                    out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_re, out_im, out_index, out_last
    );
endinterface

// File: rtl/fft_stream_core.sv
// Streaming N-point radix-2 DIT FFT: buffers one real frame in bit-reversed
// order, runs one butterfly per cycle in place, then streams bins in natural order.
module fft_stream_core #(
    parameter int LOG2N = 4,
    parameter int DW    = 16,
    parameter int TW_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    fft_stream_if.slave bus,
    output logic        busy
);
    localparam int  N        = 1 << LOG2N;
    localparam int  HN       = N / 2;
    localparam int  JW       = LOG2N - 1;
    localparam int  PW       = DW + TW_W;
    localparam real PI       = 3.14159265358979323846;
    localparam real TW_UNITY = (2.0 ** (TW_W - 1)) - 1.0;
    localparam logic signed [DW-1:0] D_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] D_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_UNLOAD  = 2'd2
    } state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    function automatic int tw_round(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(0.5 - v);
    endfunction

    function automatic int tw_cos(input int k);
        return tw_round($cos(2.0 * PI * $itor(k) / $itor(N)) * TW_UNITY);
    endfunction

    // Imaginary part of e^(-j*2*pi*k/N), hence the negated sine
    function automatic int tw_nsin(input int k);
        return -tw_round($sin(2.0 * PI * $itor(k) / $itor(N)) * TW_UNITY);
    endfunction

    function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] v);
        if (v > (DW+2)'(D_MAX))      return D_MAX;
        else if (v < (DW+2)'(D_MIN)) return D_MIN;
        else                         return v[DW-1:0];
    endfunction

    state_t                 state_r, state_s;
    logic [LOG2N-1:0]       cnt_r, idx_r;
    logic [3:0]             stage_r;
    logic [JW-1:0]          bfly_r;
    logic signed [DW-1:0]   mem_re_r [N];
    logic signed [DW-1:0]   mem_im_r [N];
    logic signed [TW_W-1:0] tw_re_s  [HN];
    logic signed [TW_W-1:0] tw_im_s  [HN];

    logic                   in_ready_s, accept_s, last_stage_s, last_bfly_s;
    logic [LOG2N-1:0]       half_s, j_ext_s, pos_s, top_s, bot_s;
    logic [3:0]             tw_shift_s;
    logic [JW-1:0]          tw_idx_s;
    logic signed [DW-1:0]   a_re_s, a_im_s, b_re_s, b_im_s;
    logic signed [TW_W-1:0] w_re_s, w_im_s;
    logic signed [PW-1:0]   m_rr_s, m_ii_s, m_ri_s, m_ir_s;
    logic signed [PW:0]     s_re_s, s_im_s, sh_re_s, sh_im_s;
    logic signed [DW+1:0]   p_re_s, p_im_s, sum_re_s, sum_im_s, dif_re_s, dif_im_s;
    logic signed [DW-1:0]   top_re_s, top_im_s, bot_re_s, bot_im_s;

    for (genvar k = 0; k < HN; k++) begin : g_tw
        assign tw_re_s[k] = TW_W'(tw_cos(k));
        assign tw_im_s[k] = TW_W'(tw_nsin(k));
    end

    assign in_ready_s   = (state_r == ST_LOAD) && !reset;
    assign accept_s     = in_ready_s && bus.in_valid;
    assign last_stage_s = (stage_r == 4'(LOG2N - 1));
    assign last_bfly_s  = last_stage_s && (bfly_r == {JW{1'b1}});

    // Butterfly addressing, twiddle lookup and complex arithmetic
    always_comb begin
        half_s     = LOG2N'(32'd1) << stage_r;
        j_ext_s    = {1'b0, bfly_r};
        pos_s      = j_ext_s & (half_s - LOG2N'(32'd1));
        top_s      = ((j_ext_s >> stage_r) << (stage_r + 4'd1)) + pos_s;
        bot_s      = top_s | half_s;
        tw_shift_s = 4'(LOG2N - 1) - stage_r;
        tw_idx_s   = JW'(pos_s << tw_shift_s);
        a_re_s     = mem_re_r[top_s];
        a_im_s     = mem_im_r[top_s];
        b_re_s     = mem_re_r[bot_s];
        b_im_s     = mem_im_r[bot_s];
        w_re_s     = tw_re_s[tw_idx_s];
        w_im_s     = tw_im_s[tw_idx_s];
        m_rr_s     = PW'(b_re_s) * PW'(w_re_s);
        m_ii_s     = PW'(b_im_s) * PW'(w_im_s);
        m_ri_s     = PW'(b_im_s) * PW'(w_re_s);
        m_ir_s     = PW'(b_re_s) * PW'(w_im_s);
        s_re_s     = (PW+1)'(m_rr_s) - (PW+1)'(m_ii_s);
        s_im_s     = (PW+1)'(m_ri_s) + (PW+1)'(m_ir_s);
        sh_re_s    = s_re_s >>> (TW_W - 1);
        sh_im_s    = s_im_s >>> (TW_W - 1);
        // W[0] is slightly below unity, so bypass keeps trivial butterflies exact
        if (tw_idx_s == '0) begin
            p_re_s = (DW+2)'(b_re_s);
            p_im_s = (DW+2)'(b_im_s);
        end else begin
            p_re_s = sh_re_s[DW+1:0];
            p_im_s = sh_im_s[DW+1:0];
        end
        sum_re_s = (DW+2)'(a_re_s) + p_re_s;
        sum_im_s = (DW+2)'(a_im_s) + p_im_s;
        dif_re_s = (DW+2)'(a_re_s) - p_re_s;
        dif_im_s = (DW+2)'(a_im_s) - p_im_s;
        top_re_s = sat(sum_re_s >>> 1);
        top_im_s = sat(sum_im_s >>> 1);
        bot_re_s = sat(dif_re_s >>> 1);
        bot_im_s = sat(dif_im_s >>> 1);
    end

    // Phase sequencing LOAD -> COMPUTE -> UNLOAD
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (accept_s && (cnt_r == LOG2N'(N - 1))) state_s = ST_COMPUTE;
                else                                      state_s = ST_LOAD;
            end
            ST_COMPUTE: begin
                if (last_bfly_s) state_s = ST_UNLOAD;
                else             state_s = ST_COMPUTE;
            end
            ST_UNLOAD: begin
                if (bus.out_ready && (idx_r == LOG2N'(N - 1))) state_s = ST_LOAD;
                else                                           state_s = ST_UNLOAD;
            end
            default: state_s = ST_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_r <= ST_LOAD;
        else       state_r <= state_s;
    end

    // Sample, butterfly and bin counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= '0;
            idx_r   <= '0;
            stage_r <= 4'd0;
            bfly_r  <= '0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (accept_s) cnt_r <= cnt_r + LOG2N'(32'd1);
                end
                ST_COMPUTE: begin
                    if (bfly_r == {JW{1'b1}}) begin
                        bfly_r  <= '0;
                        stage_r <= last_stage_s ? 4'd0 : stage_r + 4'd1;
                    end else begin
                        bfly_r  <= bfly_r + JW'(32'd1);
                    end
                end
                ST_UNLOAD: begin
                    if (bus.out_ready) idx_r <= idx_r + LOG2N'(32'd1);
                end
                default: begin
                    cnt_r <= '0;
                    idx_r <= '0;
                end
            endcase
        end
    end

    // Frame storage; deliberately not cleared by reset
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_re_r[bitrev(cnt_r)] <= bus.in_data;
            mem_im_r[bitrev(cnt_r)] <= '0;
        end else if ((state_r == ST_COMPUTE) && !reset) begin
            mem_re_r[top_s] <= top_re_s;
            mem_im_r[top_s] <= top_im_s;
            mem_re_r[bot_s] <= bot_re_s;
            mem_im_r[bot_s] <= bot_im_s;
        end
    end

    // Output drive straight from state and array
    always_comb begin
        bus.in_ready  = in_ready_s;
        bus.out_valid = (state_r == ST_UNLOAD);
        busy          = (state_r == ST_COMPUTE);
        if (state_r == ST_UNLOAD) begin
            bus.out_re    = mem_re_r[idx_r];
            bus.out_im    = mem_im_r[idx_r];
            bus.out_index = idx_r;
            bus.out_last  = (idx_r == LOG2N'(N - 1));
        end else begin
            bus.out_re    = '0;
            bus.out_im    = '0;
            bus.out_index = '0;
            bus.out_last  = 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_stream_core.sv
// Directed bench for fft_stream_core: N=16 vector table plus backpressure,
// latency and reset sequences, and impulse/DC frames on N=8 and N=64 cores.
module tb_fft_stream_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               c_in_valid;
    logic signed [15:0] c_in_data;
    logic               c_out_ready;
    logic [1:0]         sel;
    logic               busy16, busy3, busy6;

    fft_stream_if #(.LOG2N(4), .DW(16)) b16 ();
    fft_stream_if #(.LOG2N(3), .DW(16)) b3 ();
    fft_stream_if #(.LOG2N(6), .DW(16)) b6 ();

    assign b16.in_valid = c_in_valid;  assign b16.in_data = c_in_data;  assign b16.out_ready = c_out_ready;
    assign b3.in_valid  = c_in_valid;  assign b3.in_data  = c_in_data;  assign b3.out_ready  = c_out_ready;
    assign b6.in_valid  = c_in_valid;  assign b6.in_data  = c_in_data;  assign b6.out_ready  = c_out_ready;

    fft_stream_core #(.LOG2N(4), .DW(16), .TW_W(16)) u16 (.clk(clk), .reset(reset), .bus(b16), .busy(busy16));
    fft_stream_core #(.LOG2N(3), .DW(16), .TW_W(16)) u3  (.clk(clk), .reset(reset), .bus(b3),  .busy(busy3));
    fft_stream_core #(.LOG2N(6), .DW(16), .TW_W(16)) u6  (.clk(clk), .reset(reset), .bus(b6),  .busy(busy6));

    logic               m_in_ready, m_out_valid, m_out_last, m_busy;
    logic signed [15:0] m_re, m_im;
    int                 m_idx;

    always_comb begin
        case (sel)
            2'd1: begin
                m_in_ready = b3.in_ready; m_out_valid = b3.out_valid; m_out_last = b3.out_last;
                m_busy = busy3; m_re = b3.out_re; m_im = b3.out_im; m_idx = int'(b3.out_index);
            end
            2'd2: begin
                m_in_ready = b6.in_ready; m_out_valid = b6.out_valid; m_out_last = b6.out_last;
                m_busy = busy6; m_re = b6.out_re; m_im = b6.out_im; m_idx = int'(b6.out_index);
            end
            default: begin
                m_in_ready = b16.in_ready; m_out_valid = b16.out_valid; m_out_last = b16.out_last;
                m_busy = busy16; m_re = b16.out_re; m_im = b16.out_im; m_idx = int'(b16.out_index);
            end
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0][15:0] x;
        logic [15:0][15:0] er;
        logic [15:0][15:0] ei;
        logic [7:0]        tol;
    } vec_t;

    vec_t vecs [3];
    int   tone [16] = '{8192, 7568, 5793, 3135, 0, -3135, -5793, -7568,
                        -8192, -7568, -5793, -3135, 0, 3135, 5793, 7568};

    int n_checks = 0;
    int n_fail   = 0;
    int n_pts, exp_tol;
    int frame_x [64];
    int exp_re  [64];
    int exp_im  [64];
    int acc_cyc, last_hs_cyc, first_valid, busy_cnt, c0;

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_checks++;
        if ((act > exp + tol) || (act < exp - tol)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = 16'sd0;
        @(negedge clk);
        check("in_ready_during_reset", m_in_ready, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", m_in_ready, 1, 0);
        check("rst_out_valid", m_out_valid, 0, 0);
        check("rst_out_last", m_out_last, 0, 0);
        check("rst_busy", m_busy, 0, 0);
        check("rst_out_re", m_re, 0, 0);
        check("rst_out_im", m_im, 0, 0);
        check("rst_out_index", m_idx, 0, 0);
        @(posedge clk); #1;
    endtask

    task automatic push(input int d);
        int g = 0;
        c_in_valid = 1'b1; c_in_data = 16'(d);
        @(negedge clk);
        while (!m_in_ready && g < 500) begin @(negedge clk); g++; end
        if (g >= 500) check("push_timeout", g, 0, 0);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic push_frame();
        for (int i = 0; i < n_pts; i++) push(frame_x[i]);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating
    task automatic collect(input int mode, input bit hold, input int hold_data);
        int e = 0;
        int c = 0;
        busy_cnt = 0; first_valid = -1;
        while (e < n_pts && c < 1000) begin
            c_out_ready = (mode == 0) ? 1'b1 : ((c % 3) == 0);
            if (hold) begin c_in_valid = 1'b1; c_in_data = 16'(hold_data); end
            @(negedge clk);
            if (m_busy) busy_cnt++;
            if (hold) check("in_ready_low_while_busy", m_in_ready, 0, 0);
            if (m_out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                check("out_index", m_idx, e, 0);
                check($sformatf("bin%0d_re", e), m_re, exp_re[e], exp_tol);
                check($sformatf("bin%0d_im", e), m_im, exp_im[e], exp_tol);
                check("out_last", m_out_last, int'(e == n_pts - 1), 0);
                if (c_out_ready) e++;
            end
            @(posedge clk); #1;
            c++;
        end
        c_out_ready = 1'b0;
        if (e < n_pts) check("collect_timeout", e, n_pts, 0);
        last_hs_cyc = cyc;
    endtask

    task automatic load_vec(input int v);
        n_pts = 16; exp_tol = int'(vecs[v].tol);
        for (int i = 0; i < 16; i++) begin
            frame_x[i] = int'($signed(vecs[v].x[i]));
            exp_re[i]  = int'($signed(vecs[v].er[i]));
            exp_im[i]  = int'($signed(vecs[v].ei[i]));
        end
    endtask

    // kind 0: impulse of 16384 (every bin 16384/n); kind 1: DC of 1024
    task automatic load_small(input int n, input int kind);
        n_pts = n; exp_tol = 0;
        for (int i = 0; i < n; i++) begin
            frame_x[i] = (kind == 0) ? ((i == 0) ? 16384 : 0) : 1024;
            exp_re[i]  = (kind == 0) ? (16384 / n) : ((i == 0) ? 1024 : 0);
            exp_im[i]  = 0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 2'd0;
        for (int v = 0; v < 3; v++) begin
            vecs[v] = '0;
        end
        vecs[0].x[0] = 16'sd16384;
        for (int i = 0; i < 16; i++) begin
            vecs[0].er[i] = 16'sd1024;
            vecs[1].x[i]  = 16'sd1024;
            vecs[2].x[i]  = 16'(tone[i]);
        end
        vecs[1].er[0]  = 16'sd1024;
        vecs[2].er[1]  = 16'sd4096;
        vecs[2].er[15] = 16'sd4096;
        vecs[2].tol    = 8'd4;

        do_reset();

        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            push_frame();
            collect(0, 1'b0, 0);
        end

        // Backpressure with the next frame's first sample held on the input
        load_vec(0);
        push_frame();
        collect(1, 1'b1, 16384);
        push(16384);
        check("bp_accept_after_last", acc_cyc - last_hs_cyc, 1, 0);
        for (int i = 1; i < 16; i++) push(0);
        collect(0, 1'b0, 0);

        // Latency and throughput with continuous traffic
        push_frame();
        c0 = acc_cyc;
        collect(0, 1'b1, 16384);
        check("busy_cycles", busy_cnt, 32, 0);
        check("first_valid_latency", first_valid - c0, 32, 0);
        push(16384);
        check("lat_accept_after_last", acc_cyc - last_hs_cyc, 1, 0);
        for (int i = 1; i < 16; i++) push(0);
        collect(0, 1'b0, 0);

        // Reset in the middle of COMPUTE discards the DC frame
        load_vec(1);
        push_frame();
        repeat (5) @(posedge clk);
        #1;
        do_reset();
        load_vec(0);
        push_frame();
        collect(0, 1'b0, 0);

        sel = 2'd1;
        do_reset();
        load_small(8, 0);  push_frame(); collect(0, 1'b0, 0);
        load_small(8, 1);  push_frame(); collect(0, 1'b0, 0);

        sel = 2'd2;
        do_reset();
        load_small(64, 0); push_frame(); collect(0, 1'b0, 0);
        load_small(64, 1); push_frame(); collect(0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
